// File: rtl/md_ctrl_pkg.sv
// md_ctrl_pkg -- shared definitions for the multiply/divide sequencer.
//   md_op_e    : E-stage MD operation encodings (3-bit md_op field)
//   md_state_e : sequencer states
//   *_LAT_DEF  : default busy latencies
//   is_arith / is_div : operation class helpers
package md_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_RSV6  = 3'd6,
        MD_RSV7  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;

    // MULT/MULTU/DIV/DIVU occupy the sequencer; MTHI/MTLO do not.
    function automatic logic is_arith(input logic [2:0] op);
        return op <= 3'd3;
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == 3'd2) || (op == 3'd3);
    endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// md_ctrl_if -- E-stage / hazard-unit interface of the MD sequencer.
//   start, md_op, rs_data, rt_data : instruction issue from E
//   md_use_d                       : MD-class instruction sitting in D
//   busy, stall_req                : status to the hazard unit
//   hi, lo                         : architectural HI/LO for MFHI/MFLO
// slave modport is the sequencer side, master the pipeline side.
interface md_ctrl_if;

    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        md_use_d;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport slave (
        input  start, md_op, rs_data, rt_data, md_use_d,
        output busy, stall_req, hi, lo
    );

    modport master (
        output start, md_op, rs_data, rt_data, md_use_d,
        input  busy, stall_req, hi, lo
    );

endinterface

// File: rtl/md_ctrl_arith.sv
// md_arith -- purely combinational multiply/divide datapath.
//   md_op_i            : operation (only MULT/MULTU/DIV/DIVU produce results)
//   rs_i, rt_i         : operands (rs is multiplicand / dividend)
//   res_hi_o, res_lo_o : {HI,LO} result (product, or remainder/quotient)
//   div0_o             : DIV/DIVU with a zero divisor
module md_arith
    import md_ctrl_pkg::*;
(
    input  logic [2:0]  md_op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    output logic [31:0] res_hi_o,
    output logic [31:0] res_lo_o,
    output logic        div0_o
);

    logic               rt_zero;
    logic               div_ovf;
    logic [31:0]        divisor;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;

    assign rt_zero = (rt_i == 32'd0);
    // 0x80000000 / -1 overflows a 32-bit signed divide. Dividing by +1
    // instead yields exactly the architected answer (quotient 0x80000000,
    // remainder 0), and a zero divisor is likewise replaced so the
    // dividers never see an X-producing operand; that result is discarded.
    assign div_ovf = (rs_i == 32'h8000_0000) && (rt_i == 32'hFFFF_FFFF);
    assign divisor = (rt_zero || div_ovf) ? 32'd1 : rt_i;

    assign prod_s = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
    assign prod_u = {32'd0, rs_i} * {32'd0, rt_i};
    assign quot_s = $signed(rs_i) / $signed(divisor);
    assign rem_s  = $signed(rs_i) % $signed(divisor);
    assign quot_u = rs_i / divisor;
    assign rem_u  = rs_i % divisor;

    // NOTE: every output gets a default before the case so no path
    // through this block can infer a latch.
    always_comb begin
        res_hi_o = 32'd0;
        res_lo_o = 32'd0;
        div0_o   = 1'b0;
        case (md_op_e'(md_op_i))
            MD_MULT:  {res_hi_o, res_lo_o} = prod_s;
            MD_MULTU: {res_hi_o, res_lo_o} = prod_u;
            MD_DIV: begin
                res_hi_o = rem_s;
                res_lo_o = quot_s;
                div0_o   = rt_zero;
            end
            MD_DIVU: begin
                res_hi_o = rem_u;
                res_lo_o = quot_u;
                div0_o   = rt_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl -- multiply/divide sequencer for the E stage.
//   clk     : core clock, rising edge
//   reset_n : asynchronous active-low reset (aborts any pending result)
//   md      : md_ctrl_if.slave -- issue, hazard status and HI/LO
// A MULT/DIV start latches its result into pending registers and holds
// busy for MULT_LAT / DIV_LAT cycles; HI/LO are written on the final busy
// edge (skipped for a zero divisor). MTHI/MTLO write HI/LO immediately.
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,  // 1..15
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF    // 1..15
) (
    input  logic     clk,
    input  logic     reset_n,
    md_ctrl_if.slave md
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_div0_q, pend_div0_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div0;

    md_arith u_arith (
        .md_op_i  (md.md_op),
        .rs_i     (md.rs_data),
        .rt_i     (md.rt_data),
        .res_hi_o (res_hi),
        .res_lo_o (res_lo),
        .div0_o   (div0)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_hi_d   = pend_hi_q;
        pend_lo_d   = pend_lo_q;
        pend_div0_d = pend_div0_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (md.start) begin
                    if (is_arith(md.md_op)) begin
                        pend_hi_d   = res_hi;
                        pend_lo_d   = res_lo;
                        pend_div0_d = div0;
                        cnt_d       = is_div(md.md_op) ? DIV_CNT : MULT_CNT;
                        state_d     = ST_BUSY;
                    end else if (md.md_op == MD_MTHI) begin
                        hi_d = md.rs_data;
                    end else if (md.md_op == MD_MTLO) begin
                        lo_d = md.rs_data;
                    end
                end
            end
            ST_BUSY: begin
                // A start here cannot occur (the hazard unit stalls it) and
                // is deliberately not looked at.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (!pend_div0_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    // NOTE: the pending registers are reset too, so a reset mid-operation
    // leaves nothing stale that a later commit could expose.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            pend_hi_q   <= 32'd0;
            pend_lo_q   <= 32'd0;
            pend_div0_q <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_hi_q   <= pend_hi_d;
            pend_lo_q   <= pend_lo_d;
            pend_div0_q <= pend_div0_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign md.busy      = (state_q == ST_BUSY);
    // Conservative: any start (even MTHI/MTLO) stalls a dependent D op.
    assign md.stall_req = md.md_use_d & (md.start | md.busy);
    assign md.hi        = hi_q;
    assign md.lo        = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl -- self-checking bench for md_ctrl: directed cases followed by
// random operations compared against a plain-arithmetic HI/LO model.
module tb_md_ctrl;
    import md_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    md_ctrl_if bus ();

    md_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one instruction on HI/LO, and its busy length.
    task automatic model(input int op, input logic [31:0] a, input logic [31:0] b, output int lat);
        longint sa, sb, q, r;
        logic [63:0] p;
        lat = 0;
        case (op)
            0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {m_hi, m_lo} = p;
                lat = 5;
            end
            1: begin
                p = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = p;
                lat = 5;
            end
            2: begin
                lat = 10;
                if (b != 32'd0) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q = sa / sb;
                    r = sa - q * sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            3: begin
                lat = 10;
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            4: m_hi = a;
            5: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one instruction at a negedge and follow it to completion.
    task automatic do_op(input string tag, input int op, input logic [31:0] a,
                         input logic [31:0] b, input logic use_d);
        int lat;
        int n;
        chk({tag, " idle_before_start"}, 32'(bus.busy), 32'd0);
        model(op, a, b, lat);
        bus.start    = 1'b1;
        bus.md_op    = 3'(op);
        bus.rs_data  = a;
        bus.rt_data  = b;
        bus.md_use_d = use_d;
        #1;
        chk({tag, " stall_start"}, 32'(bus.stall_req), 32'(use_d));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            chk({tag, " stall_busy"}, 32'(bus.stall_req), 32'(use_d));
            @(negedge clk);
        end
        bus.md_use_d = 1'b0;
        chk({tag, " busy_cycles"}, 32'(n), 32'(lat));
        chk({tag, " hi"}, bus.hi, m_hi);
        chk({tag, " lo"}, bus.lo, m_lo);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        logic [31:0] a, b;
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.md_op    = 3'd0;
        bus.rs_data  = 32'd0;
        bus.rt_data  = 32'd0;
        bus.md_use_d = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset hi", bus.hi, 32'd0);
        chk("reset lo", bus.lo, 32'd0);
        chk("reset stall", 32'(bus.stall_req), 32'd0);
        bus.md_use_d = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);

        do_op("mult", 0, 32'hFFFF_FFFE, 32'd3, 1'b1);
        chk("mult hi const", bus.hi, 32'hFFFF_FFFF);
        chk("mult lo const", bus.lo, 32'hFFFF_FFFA);
        do_op("multu", 1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("multu hi const", bus.hi, 32'h0000_0002);
        chk("multu lo const", bus.lo, 32'hFFFF_FFFA);
        do_op("div", 2, 32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("div hi const", bus.hi, 32'hFFFF_FFFF);
        chk("div lo const", bus.lo, 32'hFFFF_FFFD);
        do_op("divu", 3, 32'd7, 32'd2, 1'b0);
        chk("divu hi const", bus.hi, 32'd1);
        chk("divu lo const", bus.lo, 32'd3);
        do_op("mthi", 4, 32'h1111_1111, 32'd0, 1'b1);
        do_op("mtlo", 5, 32'h2222_2222, 32'd0, 1'b0);
        do_op("div0", 2, 32'd12345, 32'd0, 1'b1);
        chk("div0 hi kept", bus.hi, 32'h1111_1111);
        chk("div0 lo kept", bus.lo, 32'h2222_2222);
        do_op("rsv", 6, 32'hAAAA_AAAA, 32'd5, 1'b0);
        do_op("mtlo_dead", 5, 32'hDEAD_BEEF, 32'd0, 1'b0);
        chk("mtlo lo const", bus.lo, 32'hDEAD_BEEF);
        do_op("div_ovf", 2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("ovf hi const", bus.hi, 32'd0);
        chk("ovf lo const", bus.lo, 32'h8000_0000);
        do_op("mult_pos", 0, 32'd100, 32'd9, 1'b0);

        // Reset three cycles into a DIV: abort, clear, and never commit.
        bus.start   = 1'b1;
        bus.md_op   = 3'd3;
        bus.rs_data = 32'd100;
        bus.rt_data = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("midreset busy_before", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midreset busy", 32'(bus.busy), 32'd0);
        chk("midreset hi", bus.hi, 32'd0);
        chk("midreset lo", bus.lo, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("postreset busy", 32'(bus.busy), 32'd0);
        chk("postreset hi", bus.hi, 32'd0);
        chk("postreset lo", bus.lo, 32'd0);

        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
            do_op($sformatf("rand%0d_op%0d", i, op), op, a, b, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multiply/divide sequencer for the E stage of the pipelined MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E, computes the result, and holds it pending for a fixed latency.
- Drives busy/stall to the hazard unit and commits HI/LO at the end of the latency.
- Serves MFHI/MFLO reads combinationally from the architectural HI/LO.

Parameters:
- MULT_LAT, 5, cycles busy after a MULT/MULTU start (legal range 1..15).
- DIV_LAT, 10, cycles busy after a DIV/DIVU start (legal range 1..15).

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  E-stage MD instruction valid this cycle (one-cycle pulse per instruction).
- md_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (ignored).
- rs_data  in  32  forwarded rs operand.
- rt_data  in  32  forwarded rt operand.
- md_use_d  in  1  an MD-class instruction (incl. MFHI/MFLO) is in D.
- busy  out  1  operation in flight.
- stall_req  out  1  to the hazard unit = md_use_d & (start | busy).
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset: asynchronous on reset_n low. hi=0, lo=0, busy=0, counter=0, pending regs=0, state=IDLE. Reset mid-operation aborts with no commit.
- States: IDLE, BUSY.
- IDLE, start & md_op in {0..3}:
  - Latch the computed {pend_hi, pend_lo}.
  - counter = MULT_LAT (ops 0,1) or DIV_LAT (ops 2,3).
  - Go to BUSY. busy rises the cycle after the start cycle.
- IDLE, start & MTHI: hi <= rs_data at this edge. No busy.
- IDLE, start & MTLO: lo <= rs_data at this edge. No busy.
- IDLE, start & md_op in {6,7}: no effect.
- BUSY: counter decrements each cycle. On the edge where counter==1: hi<=pend_hi, lo<=pend_lo, busy falls, return to IDLE.
  - busy is high for exactly LAT cycles.
  - New HI/LO are visible the cycle busy is first low.
- start during BUSY: ignored. The hazard unit guarantees this never happens; the bench asserts it.
- Arithmetic:
  - MULT: {hi,lo} = signed 32x32 -> 64 product.
  - MULTU: {hi,lo} = unsigned 32x32 -> 64 product.
  - DIV: lo = signed quotient, truncated toward zero; hi = remainder, sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (rt_data==0): runs the full DIV_LAT, then commit is suppressed, so hi/lo keep prior values.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. Explicit case, no simulator X/overflow.
- hi/lo outputs change only at commit or MTHI/MTLO edges. No combinational path from inputs to hi/lo.
- stall_req is combinational:
  - high in the start cycle of a mult/div start when md_use_d=1;
  - high throughout BUSY when md_use_d=1;
  - high in the start cycle of MTHI/MTLO when md_use_d=1. This is conservative and accepted.

Decomposition:
- Shared package/header (md_defs): md_op encodings (MD_MULT..MD_MTLO), default MULT_LAT/DIV_LAT, state encodings.
- One sub-module is natural: md_arith, purely combinational. It takes md_op, rs, rt and produces res_hi, res_lo, div0.
- md_ctrl holds the FSM, counter, pending regs and HI/LO.

Test Plan:
- Reset: hold reset_n low mid-BUSY (3 cycles into a DIV) -> busy=0, hi=lo=0 immediately. No commit after release.
- MULT rs=0xFFFFFFFE (-2), rt=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
- Divide by zero: preload hi=0x11111111, lo=0x22222222 via MTHI/MTLO, then DIV rt=0 -> busy 10 cycles, hi/lo unchanged.
- Stall: md_use_d=1 during a MULT start and its BUSY -> stall_req high 6 consecutive cycles (start + 5). With md_use_d=0 -> stall_req stays 0.
- MTLO rs=0xDEADBEEF in IDLE -> lo=0xDEADBEEF next cycle, busy never asserts. Overflow case DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
